// File: rtl/sq_iter_ctrl.sv
// Iterated-squaring controller: loads {dat, end_cnt, start_cnt} over AXI-Stream, drives a squaring
// core until t_cnt reaches end_cnt, then streams {dat, t_cnt} out. Optional macro SQ_ITER_CTRL_CYC_CNT_EN.
module sq_iter_ctrl #(
  parameter int unsigned AXI_LEN  = 32,
  parameter int unsigned T_LEN    = 64,
  parameter int unsigned DAT_BITS = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                start_xfer,
  output logic                err,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [AXI_LEN-1:0]  s_axis_tdata,
  input  logic                s_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [AXI_LEN-1:0]  m_axis_tdata,
  output logic                m_axis_tlast,
  output logic                core_start,
  output logic [DAT_BITS-1:0] core_in,
  input  logic                core_val,
  input  logic [DAT_BITS-1:0] core_out,
  output logic [31:0]         cyc_cnt
);

  localparam int unsigned InVb     = DAT_BITS + 2 * T_LEN;
  localparam int unsigned InBeats  = (InVb + AXI_LEN - 1) / AXI_LEN;
  localparam int unsigned InW      = InBeats * AXI_LEN;
  localparam int unsigned OutVb    = DAT_BITS + T_LEN;
  localparam int unsigned OutBeats = (OutVb + AXI_LEN - 1) / AXI_LEN;
  localparam int unsigned OutW     = OutBeats * AXI_LEN;
  localparam int unsigned CntW     = $clog2(InBeats + 2);
  localparam int unsigned OcntW    = $clog2(OutBeats + 1);

  localparam logic [CntW-1:0]  InBeatsC = CntW'(InBeats);
  localparam logic [CntW-1:0]  InCntMax = CntW'(InBeats + 1);
  localparam logic [OcntW-1:0] OutLast  = OcntW'(OutBeats - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StSend, StDone} state_e;

  state_e           state_q, state_d;
  logic [InW-1:0]   frm_q, frm_d;
  logic [CntW-1:0]  in_cnt_q, in_cnt_d;
  logic [T_LEN-1:0] t_cnt_q, t_cnt_d;
  logic [OcntW-1:0] out_cnt_q, out_cnt_d;
  logic             busy_q, busy_d;
  logic             skip_q, skip_d;
  logic             err_q, err_d;
  logic             xfer_q, xfer_d;

  logic [InW-1:0]   frm_sh;
  logic [CntW-1:0]  in_cnt_inc;
  logic [T_LEN-1:0] t_inc;
  logic [OutW-1:0]  out_vec;
  logic             in_fire, val_hit, out_fire, frame_ok;

  // Frame is shifted in from the top so beat 0 ends up in the LSBs after InBeats beats.
  assign frm_sh     = {s_axis_tdata, frm_q[InW-1:AXI_LEN]};
  assign in_cnt_inc = (in_cnt_q == InCntMax) ? in_cnt_q : in_cnt_q + 1'b1;
  assign in_fire    = (state_q == StLoad) && s_axis_tvalid;
  assign frame_ok   = in_fire && s_axis_tlast && (in_cnt_inc == InBeatsC);
  assign val_hit    = (state_q == StRun) && busy_q && core_val;
  assign t_inc      = t_cnt_q + 1'b1;
  assign out_fire   = (state_q == StSend) && m_axis_tready;

  always_comb begin
    out_vec            = '0;
    out_vec[OutVb-1:0] = {frm_q[2*T_LEN +: DAT_BITS], t_cnt_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      frm_q     <= '0;
      in_cnt_q  <= '0;
      t_cnt_q   <= '0;
      out_cnt_q <= '0;
      busy_q    <= 1'b0;
      skip_q    <= 1'b0;
      err_q     <= 1'b0;
      xfer_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frm_q     <= frm_d;
      in_cnt_q  <= in_cnt_d;
      t_cnt_q   <= t_cnt_d;
      out_cnt_q <= out_cnt_d;
      busy_q    <= busy_d;
      skip_q    <= skip_d;
      err_q     <= err_d;
      xfer_q    <= xfer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (ap_start) state_d = StLoad;
      StLoad: if (frame_ok) state_d = StRun;
      StRun: begin
        if (skip_q) state_d = StSend;
        else if (val_hit && (t_inc == frm_q[T_LEN +: T_LEN])) state_d = StSend;
      end
      StSend: if (out_fire && (out_cnt_q == OutLast)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    frm_d     = frm_q;
    in_cnt_d  = in_cnt_q;
    t_cnt_d   = t_cnt_q;
    out_cnt_d = out_cnt_q;
    busy_d    = busy_q;
    skip_d    = skip_q;
    err_d     = 1'b0;
    xfer_d    = 1'b0;
    if (in_fire) begin
      // Beats past InBeats are counted but not stored.
      if (in_cnt_q < InBeatsC) frm_d = frm_sh;
      if (s_axis_tlast) begin
        in_cnt_d = '0;
        if (frame_ok) begin
          t_cnt_d = frm_sh[T_LEN-1:0];
          skip_d  = frm_sh[T_LEN-1:0] >= frm_sh[T_LEN +: T_LEN];
          busy_d  = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        in_cnt_d = in_cnt_inc;
      end
    end
    if (core_start) busy_d = 1'b1;
    if (val_hit) begin
      frm_d[2*T_LEN +: DAT_BITS] = core_out;
      t_cnt_d                    = t_inc;
      busy_d                     = 1'b0;
    end
    if (out_fire) out_cnt_d = out_cnt_q + 1'b1;
    if ((state_d == StSend) && (state_q != StSend)) begin
      out_cnt_d = '0;
      xfer_d    = 1'b1;
    end
  end

  always_comb begin
    s_axis_tready = (state_q == StLoad);
    m_axis_tvalid = (state_q == StSend);
    m_axis_tlast  = (state_q == StSend) && (out_cnt_q == OutLast);
    m_axis_tdata  = '0;
    if (state_q == StSend) m_axis_tdata = out_vec[out_cnt_q * AXI_LEN +: AXI_LEN];
    core_start    = (state_q == StRun) && !skip_q && !busy_q;
    core_in       = frm_q[2*T_LEN +: DAT_BITS];
    ap_done       = (state_q == StDone);
    start_xfer    = xfer_q;
    err           = err_q;
  end

`ifdef SQ_ITER_CTRL_CYC_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == StLoad) && (state_d == StRun)) cyc_d = '0;
    else if (state_q == StRun) cyc_d = cyc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign cyc_cnt = cyc_q;
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_sq_iter_ctrl.sv
// Scoreboard bench for sq_iter_ctrl with a +1 squaring-core model of 3-cycle latency.
`timescale 1ns/1ps
module tb_sq_iter_ctrl;

  localparam int unsigned AW       = 32;
  localparam int unsigned TW       = 64;
  localparam int unsigned DW       = 1024;
  localparam int unsigned InVb     = DW + 2 * TW;
  localparam int unsigned InBeats  = (InVb + AW - 1) / AW;
  localparam int unsigned InW      = InBeats * AW;
  localparam int unsigned OutVb    = DW + TW;
  localparam int unsigned OutBeats = (OutVb + AW - 1) / AW;
  localparam int unsigned OutW     = OutBeats * AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          ap_start, ap_done, start_xfer, err;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [AW-1:0] s_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [AW-1:0] m_axis_tdata;
  logic          core_start;
  logic [DW-1:0] core_in;
  logic          core_val = 1'b0;
  logic [DW-1:0] core_out = '0;
  logic [31:0]   cyc_cnt;

  int total = 0;
  int bad   = 0;
  int sx_cnt = 0, ad_cnt = 0, cs_cnt = 0, er_cnt = 0, cv_cnt = 0;
  logic [AW:0] exp_q[$];

  sq_iter_ctrl #(.AXI_LEN(AW), .T_LEN(TW), .DAT_BITS(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .start_xfer    (start_xfer),
    .err           (err),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .core_start    (core_start),
    .core_in       (core_in),
    .core_val      (core_val),
    .core_out      (core_out),
    .cyc_cnt       (cyc_cnt)
  );

  always #5 clk = ~clk;

  // Core model keeps running through reset so an in-flight result can arrive afterwards.
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [DW-1:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    v1       <= core_start;
    d1       <= core_in + 1'b1;
    v2       <= v1;
    d2       <= d1;
    core_val <= v2;
    core_out <= d2;
  end

  always @(posedge clk) begin
    if (start_xfer) sx_cnt++;
    if (ap_done)    ad_cnt++;
    if (core_start) cs_cnt++;
    if (err)        er_cnt++;
    if (core_val)   cv_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called and returns on a falling edge.
  task automatic load_frame(input logic [DW-1:0] dat, input logic [TW-1:0] st,
                            input logic [TW-1:0] en, input bit do_start, input int nb);
    logic [InW-1:0] fv;
    fv           = '0;
    fv[InVb-1:0] = {dat, en, st};
    if (do_start) begin
      ap_start = 1'b1;
      @(negedge clk);
      ap_start = 1'b0;
    end
    for (int i = 0; i < nb; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = (i < int'(InBeats)) ? fv[i*AW +: AW] : AW'($urandom);
      s_axis_tlast  = (i == nb - 1);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic run_frame(input logic [DW-1:0] dat, input logic [TW-1:0] st,
                           input logic [TW-1:0] en, input bit do_start, input bit toggle,
                           input string tag);
    logic [OutW-1:0] ov;
    logic [DW-1:0]   ed;
    logic [TW-1:0]   et;
    logic [AW:0]     e;
    int              sx0, ad0, cs0, n, iters;
    sx0 = sx_cnt;
    ad0 = ad_cnt;
    cs0 = cs_cnt;
    if (st < en) begin
      ed    = dat + DW'(en - st);
      et    = en;
      iters = int'(en - st);
    end else begin
      ed    = dat;
      et    = st;
      iters = 0;
    end
    ov            = '0;
    ov[OutVb-1:0] = {ed, et};
    for (int i = 0; i < int'(OutBeats); i++) exp_q.push_back({i == int'(OutBeats) - 1, ov[i*AW +: AW]});
    load_frame(dat, st, en, do_start, int'(InBeats));
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      m_axis_tready = toggle ? (n % 2 == 1) : 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        e = exp_q.pop_front();
        check_eq({tag, "_beat"}, {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, e});
      end else if (m_axis_tvalid) begin
        check_eq({tag, "_hold"}, {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, exp_q[0]});
      end
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq({tag, "_timeout_left"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq({tag, "_start_xfer"}, 64'(sx_cnt - sx0), 64'd1);
    check_eq({tag, "_ap_done"}, 64'(ad_cnt - ad0), 64'd1);
    check_eq({tag, "_core_starts"}, 64'(cs_cnt - cs0), 64'(iters));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
    check_eq({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check_eq({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    check_eq({tag, "_m_tdata"}, 64'(m_axis_tdata), 64'd0);
    check_eq({tag, "_core_start"}, 64'(core_start), 64'd0);
    check_eq({tag, "_core_in_nz"}, 64'(core_in != '0), 64'd0);
    check_eq({tag, "_flags"}, 64'({ap_done, start_xfer, err}), 64'd0);
    check_eq({tag, "_cyc_cnt"}, 64'(cyc_cnt), 64'd0);
  endtask

  initial begin
    int er0, base, n;
    reset         = 1'b1;
    ap_start      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    run_frame(DW'(5), TW'(0), TW'(100), 1'b1, 1'b0, "basic");
`ifdef SQ_ITER_CTRL_CYC_CNT_EN
    check_eq("cyc_cnt_basic", 64'(cyc_cnt), 64'd400);
`else
    check_eq("cyc_cnt_basic", 64'(cyc_cnt), 64'd0);
`endif

    run_frame(DW'(7), TW'(10), TW'(10), 1'b1, 1'b0, "equal");
    run_frame(DW'(9), TW'(20), TW'(10), 1'b1, 1'b0, "start_gt_end");

    er0 = er_cnt;
    load_frame(DW'(0), TW'(0), TW'(0), 1'b1, int'(InBeats) - 1);
    @(negedge clk);
    check_eq("short_err", 64'(er_cnt - er0), 64'd1);
    check_eq("short_stay_load", 64'(s_axis_tready), 64'd1);
    load_frame(DW'(0), TW'(0), TW'(0), 1'b0, int'(InBeats) + 2);
    @(negedge clk);
    check_eq("long_err", 64'(er_cnt - er0), 64'd2);
    check_eq("long_stay_load", 64'(s_axis_tready), 64'd1);
    run_frame(DW'(1), TW'(0), TW'(4), 1'b0, 1'b0, "after_err");

    run_frame(DW'(5), TW'(0), TW'(100), 1'b1, 1'b1, "toggle");

    base = cv_cnt;
    load_frame(DW'(3), TW'(0), TW'(100), 1'b1, int'(InBeats));
    n = 0;
    while ((cv_cnt - base) < 50 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("midrun_reached_50", 64'(cv_cnt - base), 64'd50);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrun");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("stale_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("stale_idle_tready", 64'(s_axis_tready), 64'd0);
    run_frame(DW'(2), TW'(0), TW'(3), 1'b1, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
